// File: rtl/soc_top_if.sv
// Core-to-memory bus: one instruction fetch port and one data port.
interface soc_top_if;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic [31:0] daddr;
    logic [31:0] drdata;
    logic [31:0] dwdata;
    logic [3:0]  dbe;

    modport master (output iaddr, daddr, dwdata, dbe, input idata, drdata);
    modport slave  (input iaddr, daddr, dwdata, dbe, output idata, drdata);
endinterface

// File: rtl/soc_top.sv
// Minimal single-cycle RV32I SoC: one core plus one shared program/data memory.

// Program counter holder; the core computes the next PC combinationally.
module rv_if #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next_i,
    output logic [31:0] if_pc_o
);
    logic [31:0] pc_d, pc_q;

    // next PC comes straight from the execute logic
    always_comb pc_d = pc_next_i;

    // PC register, reloaded with RESET_PC while reset is asserted (active-high)
    always_ff @(posedge clk) begin
        if (rst_n) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign if_pc_o = pc_q;
endmodule

// 32 x 32 register file: two async read ports, one write port, x0 hardwired.
module rv_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] regs [0:31];

    // reset clears the whole file; x0 is never written afterwards
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            regs[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs[ra2_i];
endmodule

// Word-addressed memory shared by fetch and data; addresses wrap modulo depth.
module rv_rom #(
    parameter int MEM_AW = 12
) (
    input logic        clk,
    soc_top_if.slave   bus
);
    logic [31:0] rom_mem [0:2**MEM_AW-1];
    logic        unused_addr;

    assign bus.idata  = rom_mem[bus.iaddr[MEM_AW+1:2]];
    assign bus.drdata = rom_mem[bus.daddr[MEM_AW+1:2]];
    assign unused_addr = ^{bus.iaddr[31:MEM_AW+2], bus.iaddr[1:0],
                           bus.daddr[31:MEM_AW+2], bus.daddr[1:0]};

    // byte-lane store; fetch sees the new word on the following cycle
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.dbe[b]) rom_mem[bus.daddr[MEM_AW+1:2]][8*b +: 8] <= bus.dwdata[8*b +: 8];
    end
endmodule

// Single-cycle RV32I datapath; anything outside the executed subset is a NOP.
module rvcore #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic        clk,
    input logic        rst_n,
    soc_top_if.master  bus
);
    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f,
                           OPC_JALR = 7'h67, OPC_BR = 7'h63, OPC_LD = 7'h03,
                           OPC_ST = 7'h23, OPC_OPI = 7'h13, OPC_OP = 7'h33;

    logic [31:0] pc, pc_next, instr, rs1_v, rs2_v, wd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_y, ld_b, ld_h, ld_w, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        we, alt, take, ld_ok;

    rv_if #(.RESET_PC(RESET_PC)) IF_ins (
        .clk(clk), .rst_n(rst_n), .pc_next_i(pc_next), .if_pc_o(pc)
    );

    rv_regs regs_ins (
        .clk(clk), .rst_n(rst_n), .ra1_i(rs1), .ra2_i(rs2), .rd1_o(rs1_v),
        .rd2_o(rs2_v), .we_i(we), .wa_i(rd), .wd_i(wd)
    );

    assign bus.iaddr  = pc;
    assign instr      = bus.idata;
    assign bus.daddr  = d_addr;
    assign bus.dwdata = d_wdata;
    assign bus.dbe    = d_be;

    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ALU; instr[30] selects SUB only for register ops and SRA for both forms
    always_comb begin
        alu_b = (opc == OPC_OP) ? rs2_v : imm_i;
        alt   = instr[30] && (opc == OPC_OP || f3 == 3'd5);
        case (f3)
            3'd0:    alu_y = alt ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1:    alu_y = rs1_v << alu_b[4:0];
            3'd2:    alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'd3:    alu_y = {31'b0, rs1_v < alu_b};
            3'd4:    alu_y = rs1_v ^ alu_b;
            3'd5:    alu_y = alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'd6:    alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    // branch condition; reserved funct3 codes never branch
    always_comb begin
        case (f3)
            3'd0:    take = rs1_v == rs2_v;
            3'd1:    take = rs1_v != rs2_v;
            3'd4:    take = $signed(rs1_v) <  $signed(rs2_v);
            3'd5:    take = $signed(rs1_v) >= $signed(rs2_v);
            3'd6:    take = rs1_v <  rs2_v;
            3'd7:    take = rs1_v >= rs2_v;
            default: take = 1'b0;
        endcase
    end

    // load lane extraction and sign/zero extension
    always_comb begin
        ld_b  = bus.drdata >> {d_addr[1:0], 3'b000};
        ld_h  = bus.drdata >> {d_addr[1], 4'b0000};
        ld_ok = 1'b1;
        case (f3)
            3'd0:    ld_w = {{24{ld_b[7]}}, ld_b[7:0]};
            3'd1:    ld_w = {{16{ld_h[15]}}, ld_h[15:0]};
            3'd2:    ld_w = bus.drdata;
            3'd4:    ld_w = {24'b0, ld_b[7:0]};
            3'd5:    ld_w = {16'b0, ld_h[15:0]};
            default: begin ld_w = '0; ld_ok = 1'b0; end
        endcase
    end

    // main decode: next PC, register write and store lanes
    always_comb begin
        pc_next = pc + 32'd4;
        we      = 1'b0;
        wd      = alu_y;
        d_addr  = rs1_v + imm_i;
        d_wdata = rs2_v;
        d_be    = 4'b0000;
        case (opc)
            OPC_LUI:   begin we = 1'b1; wd = imm_u; end
            OPC_AUIPC: begin we = 1'b1; wd = pc + imm_u; end
            OPC_JAL:   begin we = 1'b1; wd = pc + 32'd4; pc_next = pc + imm_j; end
            OPC_JALR:  begin we = 1'b1; wd = pc + 32'd4; pc_next = (rs1_v + imm_i) & ~32'h1; end
            OPC_BR:    if (take) pc_next = pc + imm_b;
            OPC_LD:    begin we = ld_ok; wd = ld_w; end
            OPC_ST: begin
                d_addr = rs1_v + imm_s;
                case (f3)
                    3'd0: begin d_wdata = {4{rs2_v[7:0]}};  d_be = 4'b0001 << d_addr[1:0]; end
                    3'd1: begin d_wdata = {2{rs2_v[15:0]}}; d_be = d_addr[1] ? 4'b1100 : 4'b0011; end
                    3'd2: d_be = 4'b1111;
                    default: ;
                endcase
            end
            OPC_OPI, OPC_OP: we = 1'b1;
            default: ;
        endcase
        // no stores while held in reset, so memory survives a mid-run reset
        if (rst_n) d_be = 4'b0000;
    end
endmodule

// SoC top: core and memory joined by the internal bus.
module soc_top #(
    parameter int          MEM_AW   = 12,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic clk,
    input logic rst_n
);
    soc_top_if bus ();

    rvcore #(.RESET_PC(RESET_PC)) rvcore_ins (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    rv_rom #(.MEM_AW(MEM_AW))     rom_ins    (.clk(clk), .bus(bus.slave));
endmodule

// File: tb/tb_soc_top.sv
// Bench for soc_top: directed programs plus random straight-line/branch
// programs checked against an instruction-level reference model.
module tb_soc_top;
    localparam int P = 48;
    localparam int K_LUI = 0, K_AUIPC = 1, K_ALUI = 2, K_ALU = 3, K_LOAD = 4, K_STORE = 5, K_BR = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int errors = 0;
    int checks = 0;

    logic [31:0] img [0:4095];
    logic [7:0]  mb  [0:16383];
    logic [31:0] mr  [0:31];
    logic [31:0] m_pc;
    logic [31:0] m_val;
    int          m_rd;
    int d_kind [0:P-1];
    int d_rd   [0:P-1];
    int d_rs1  [0:P-1];
    int d_rs2  [0:P-1];
    int d_aop  [0:P-1];
    int d_imm  [0:P-1];

    always #5 clk = ~clk;

    soc_top #(.MEM_AW(12), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] i = imm, a = rs1, f = f3, d = rd, o = op;
        return {i[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [31:0] s = f7, b = rs2, a = rs1, f = f3, d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] i = imm, b = rs2, a = rs1, f = f3;
        return {i[11:5], b[4:0], a[4:0], f[2:0], i[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] i = imm, b = rs2, a = rs1, f = f3;
        return {i[12], i[10:5], b[4:0], a[4:0], f[2:0], i[4:1], i[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_u(int imm, int rd, int op);
        logic [31:0] i = imm, d = rd, o = op;
        return {i[31:12], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] e_j(int imm, int rd);
        logic [31:0] i = imm, d = rd;
        return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] dreg(int i);
        return dut.rvcore_ins.regs_ins.regs[i];
    endfunction
    function automatic logic [31:0] dpc();
        return dut.rvcore_ins.IF_ins.if_pc_o;
    endfunction
    function automatic logic [31:0] regs_or();
        logic [31:0] acc = '0;
        for (int i = 1; i < 32; i++) acc |= dut.rvcore_ins.regs_ins.regs[i];
        return acc;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = '0;
    endtask

    // hold reset over one edge, then preload memory and release
    task automatic boot();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) dut.rom_ins.rom_mem[i] <= img[i];
        rst_n = 1'b0;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // reference ALU by operation name: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        int sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << sh;
            3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: return (a < b) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a >> sh;
            7: return 32'($signed(a) >>> sh);
            8: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int alu_f3(int op);
        case (op)
            0, 1: return 0;
            2: return 1;
            3: return 2;
            4: return 3;
            5: return 4;
            6, 7: return 5;
            8: return 6;
            default: return 7;
        endcase
    endfunction

    task automatic m_wr(int rd, logic [31:0] v);
        m_rd  = rd;
        m_val = (rd == 0) ? 32'd0 : v;
        if (rd != 0) mr[rd] = v;
    endtask

    // execute one instruction of the random program at the model PC
    task automatic m_step();
        int idx;
        logic [31:0] a, b, im, ad, v, npc;
        logic tk;
        idx  = int'(m_pc >> 2);
        npc  = m_pc + 32'd4;
        m_rd = -1;
        if (idx < P) begin
            a  = mr[d_rs1[idx]];
            b  = mr[d_rs2[idx]];
            im = d_imm[idx];
            case (d_kind[idx])
                K_LUI:   m_wr(d_rd[idx], im);
                K_AUIPC: m_wr(d_rd[idx], m_pc + im);
                K_ALUI:  m_wr(d_rd[idx], ref_alu(d_aop[idx], a, im));
                K_ALU:   m_wr(d_rd[idx], ref_alu(d_aop[idx], a, b));
                K_LOAD: begin
                    ad = a + im;
                    case (d_aop[idx])
                        0: v = {{24{mb[ad][7]}}, mb[ad]};
                        1: v = {{16{mb[ad+1][7]}}, mb[ad+1], mb[ad]};
                        2: v = {mb[ad+3], mb[ad+2], mb[ad+1], mb[ad]};
                        3: v = {24'b0, mb[ad]};
                        default: v = {16'b0, mb[ad+1], mb[ad]};
                    endcase
                    m_wr(d_rd[idx], v);
                end
                K_STORE: begin
                    ad = a + im;
                    mb[ad] = b[7:0];
                    if (d_aop[idx] >= 1) mb[ad+1] = b[15:8];
                    if (d_aop[idx] == 2) begin mb[ad+2] = b[23:16]; mb[ad+3] = b[31:24]; end
                end
                default: begin
                    case (d_aop[idx])
                        0: tk = a == b;
                        1: tk = a != b;
                        2: tk = $signed(a) <  $signed(b);
                        3: tk = $signed(a) >= $signed(b);
                        4: tk = a <  b;
                        default: tk = a >= b;
                    endcase
                    if (tk) npc = m_pc + im;
                end
            endcase
        end
        m_pc = npc;
    endtask

    // build one random program into the descriptor table and image
    task automatic gen_prog();
        logic [31:0] t;
        int sz, f3;
        for (int i = 0; i < P; i++) begin
            d_kind[i] = int'($urandom_range(0, 6));
            d_rd[i]   = int'($urandom_range(0, 31));
            d_rs1[i]  = int'($urandom_range(0, 31));
            d_rs2[i]  = int'($urandom_range(0, 31));
            d_aop[i]  = 0;
            d_imm[i]  = 0;
            case (d_kind[i])
                K_LUI, K_AUIPC: begin
                    t = $urandom & 32'hFFFF_F000;
                    d_imm[i] = int'(t);
                    img[i] = e_u(d_imm[i], d_rd[i], (d_kind[i] == K_LUI) ? 'h37 : 'h17);
                end
                K_ALUI: begin
                    d_aop[i] = int'($urandom_range(0, 9));
                    if (d_aop[i] == 1) d_aop[i] = 0;
                    if (d_aop[i] == 2 || d_aop[i] == 6 || d_aop[i] == 7) begin
                        d_imm[i] = int'($urandom_range(0, 31));
                        img[i] = e_i(d_imm[i] + ((d_aop[i] == 7) ? 'h400 : 0), d_rs1[i],
                                     alu_f3(d_aop[i]), d_rd[i], 'h13);
                    end else begin
                        d_imm[i] = int'($urandom_range(0, 4095)) - 2048;
                        img[i] = e_i(d_imm[i], d_rs1[i], alu_f3(d_aop[i]), d_rd[i], 'h13);
                    end
                end
                K_ALU: begin
                    d_aop[i] = int'($urandom_range(0, 9));
                    img[i] = e_r((d_aop[i] == 1 || d_aop[i] == 7) ? 'h20 : 0, d_rs2[i], d_rs1[i],
                                 alu_f3(d_aop[i]), d_rd[i]);
                end
                K_LOAD: begin
                    d_aop[i] = int'($urandom_range(0, 4));
                    sz = (d_aop[i] == 2) ? 4 : (d_aop[i] == 1 || d_aop[i] == 4) ? 2 : 1;
                    d_rs1[i] = 0;
                    d_imm[i] = (1024 + int'($urandom_range(0, 1023))) & ~(sz - 1);
                    f3 = (d_aop[i] == 3) ? 4 : (d_aop[i] == 4) ? 5 : d_aop[i];
                    img[i] = e_i(d_imm[i], 0, f3, d_rd[i], 'h03);
                end
                K_STORE: begin
                    d_aop[i] = int'($urandom_range(0, 2));
                    sz = (d_aop[i] == 2) ? 4 : (d_aop[i] == 1) ? 2 : 1;
                    d_rs1[i] = 0;
                    d_imm[i] = (1024 + int'($urandom_range(0, 1023))) & ~(sz - 1);
                    img[i] = e_s(d_imm[i], d_rs2[i], 0, d_aop[i]);
                end
                default: begin
                    d_aop[i] = int'($urandom_range(0, 5));
                    d_imm[i] = 4 * int'($urandom_range(2, 4));
                    f3 = (d_aop[i] < 2) ? d_aop[i] : d_aop[i] + 2;
                    img[i] = e_b(d_imm[i], d_rs2[i], d_rs1[i], f3);
                end
            endcase
        end
    endtask

    initial begin
        // ---- T1: done/pass flags then self-loop
        clear_img();
        img[0] = e_i(1, 0, 0, 26, 'h13);
        img[1] = e_i(1, 0, 0, 27, 'h13);
        img[2] = e_j(0, 0);
        boot();
        chk("reset_pc", dpc(), 32'h0);
        chk("reset_regs", regs_or(), 32'h0);
        step(3);
        chk("t1_x26", dreg(26), 32'd1);
        chk("t1_x27", dreg(27), 32'd1);
        chk("t1_pc", dpc(), 32'h8);
        step(5);
        chk("t1_pc_hold", dpc(), 32'h8);

        // ---- T2: store/load lanes, then a one-cycle reset mid-program
        clear_img();
        img[0] = e_u('h12345000, 5, 'h37);
        img[1] = e_i('h678, 5, 0, 5, 'h13);
        img[2] = e_s('h100, 5, 0, 2);
        img[3] = e_i('h101, 0, 0, 6, 'h03);
        img[4] = e_i('h102, 0, 5, 7, 'h03);
        boot();
        step(3);
        chk("t2_x5_mid", dreg(5), 32'h12345678);
        chk("t2_mem64", dut.rom_ins.rom_mem[64], 32'h12345678);
        rst_n = 1'b1;
        step(1);
        chk("t2_rst_pc", dpc(), 32'h0);
        chk("t2_rst_regs", regs_or(), 32'h0);
        chk("t2_rst_mem", dut.rom_ins.rom_mem[64], 32'h12345678);
        rst_n = 1'b0;
        step(5);
        chk("t2_x5", dreg(5), 32'h12345678);
        chk("t2_x6_lb", dreg(6), 32'h00000056);
        chk("t2_x7_lhu", dreg(7), 32'h00001234);

        // ---- T3: signed/unsigned branches both taken
        clear_img();
        img[0] = e_i(-1, 0, 0, 1, 'h13);
        img[1] = e_b(8, 1, 0, 6);
        img[2] = e_i(5, 0, 0, 2, 'h13);
        img[3] = e_b(8, 0, 1, 4);
        img[4] = e_i(7, 0, 0, 3, 'h13);
        boot();
        step(3);
        chk("t3_x1", dreg(1), 32'hFFFFFFFF);
        chk("t3_x2", dreg(2), 32'h0);
        chk("t3_x3", dreg(3), 32'h0);
        chk("t3_pc", dpc(), 32'h14);

        // ---- T4: JAL to 0x10, AUIPC, JALR with odd target
        clear_img();
        img[0] = e_j(16, 0);
        img[4] = e_u(0, 4, 'h17);
        img[5] = e_i(9, 4, 0, 5, 'h67);
        boot();
        step(1);
        chk("t4_jal_pc", dpc(), 32'h10);
        step(2);
        chk("t4_x4", dreg(4), 32'h10);
        chk("t4_x5", dreg(5), 32'h18);
        chk("t4_pc", dpc(), 32'h18);

        // ---- T5: write to x0 and an unknown opcode
        clear_img();
        img[0] = e_i(5, 0, 0, 0, 'h13);
        img[1] = 32'hFFFFFFFF;
        img[2] = e_i(3, 0, 0, 9, 'h13);
        boot();
        step(2);
        chk("t5_x0", dreg(0), 32'h0);
        chk("t5_pc", dpc(), 32'h8);
        chk("t5_regs", regs_or(), 32'h0);
        step(1);
        chk("t5_x9", dreg(9), 32'd3);

        // ---- random programs against the reference model
        for (int r = 0; r < 4; r++) begin
            clear_img();
            for (int i = 0; i < 16384; i++) mb[i] = 8'h0;
            for (int w = 256; w < 512; w++) begin
                img[w] = $urandom;
                {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]} = img[w];
            end
            gen_prog();
            for (int i = 0; i < 32; i++) mr[i] = '0;
            m_pc = '0;
            boot();
            for (int s = 0; s < P + 4; s++) begin
                step(1);
                m_step();
                chk($sformatf("r%0d_s%0d_pc", r, s), dpc(), m_pc);
                if (m_rd >= 0) chk($sformatf("r%0d_s%0d_x%0d", r, s, m_rd), dreg(m_rd), m_val);
            end
            for (int i = 0; i < 32; i++) chk($sformatf("r%0d_end_x%0d", r, i), dreg(i), mr[i]);
            for (int w = 256; w < 512; w++)
                chk($sformatf("r%0d_mem%0d", r, w), dut.rom_ins.rom_mem[w],
                    {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Minimal RISC-V SoC: single-cycle RV32I core (`rvcore_ins`) plus one word-addressed memory (`rom_ins`) holding both program and data.
- Memory is preloaded from a hex image via `$readmemh`. Execution starts at address 0 after reset.
- Benches observe pass/fail through architectural registers x26 (done flag) and x27 (pass flag), following the riscv-tests convention.

Parameters:
- MEM_AW, 12, word-address width of memory (depth = 2^MEM_AW 32-bit words).
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-high (name kept per codebase convention; asserted = 1).

Behaviour:
- Fixed hierarchy, probed by benches:
  - `rom_ins.rom_mem[0:2^MEM_AW-1]` (32-bit words, loadable by `$readmemh`).
  - `rvcore_ins.regs_ins.regs[0:31]` (32-bit).
  - `rvcore_ins.IF_ins.if_pc_o` (32-bit current PC).
- Reset (rst_n=1 at a rising edge):
  - PC <= RESET_PC.
  - regs[1..31] <= 0.
  - Memory contents are NOT cleared.
- Out of reset, exactly one instruction retires per clock. No stalls, no pipeline, no hazards.
- Fetch: instruction = rom_mem[pc[MEM_AW+1:2]], combinational read. Upper address bits are ignored, so addresses wrap modulo memory size.
- ISA: full RV32I.
  - LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - OP-IMM and OP ALU operations, including SLT/SLTU and shifts using shamt[4:0].
  - FENCE, ECALL, EBREAK, CSR* and any unknown opcode execute as NOP (PC+4, no writes).
- Next PC:
  - Taken branch: PC+imm_B.
  - JAL: PC+imm_J.
  - JALR: (rs1+imm_I) & ~1.
  - Otherwise: PC+4.
  - JAL/JALR write PC+4 to rd.
  - Misaligned targets do not trap; fetch ignores pc[1:0].
- Register file:
  - Two combinational read ports, one write port on the clock edge.
  - x0 always reads 0; writes to x0 are discarded.
  - Same-cycle read of a register being written returns the old value (single-cycle design, no bypass needed).
- Data port on the same memory:
  - Combinational read of word at addr[MEM_AW+1:2].
  - Loads extract the byte by addr[1:0] or the halfword by addr[1], then sign- or zero-extend.
  - LW ignores addr[1:0].
  - Stores write on the rising edge with byte enables: SB one lane by addr[1:0], SH two lanes by addr[1], SW all four lanes.
  - Instruction fetch sees stored data on the next cycle (self-modifying code allowed).
- Arithmetic: 32-bit wrap-around, no overflow detection. SRA/SRAI arithmetic, SRL logical.
- Reset mid-run: next edge with rst_n=1 restarts at RESET_PC with cleared registers; memory keeps prior stores.
- No outputs: completion is signalled only through register state (x26=1 done, x27=1 pass, x3=test number on failure).

Test Plan:
- Image `addi x26,x0,1; addi x27,x0,1; jal x0,0` -> after reset release, within 3 cycles regs[26]=1, regs[27]=1; PC then stays at 8.
- Image with `lui x5,0x12345; addi x5,x5,0x678; sw x5,0x100(x0); lb x6,0x101(x0); lhu x7,0x102(x0)` -> x5=0x12345678, x6=0x00000056, x7=0x00001234, rom_mem[64]=0x12345678.
- Branch test: `addi x1,x0,-1; bltu x0,x1,+8; addi x2,x0,5; blt x1,x0,+8; addi x3,x0,7` -> x2=0, x3=0 (both branches taken).
- JALR/AUIPC: `auipc x4,0` at 0x10, `jalr x5,9(x4)` -> x4=0x10, x5=0x18, next PC=0x18 (bit 0 cleared).
- Writes to x0 (`addi x0,x0,5`) -> regs[0] reads 0; unknown opcode 0xFFFFFFFF -> PC+4, no register change.
- Assert rst_n=1 for one cycle mid-program -> PC=0, regs[1..31]=0 next cycle, memory unchanged, program reruns to same final state.
